bus_term_fifo: RTL

//  Per-terminal transmit FIFO sitting directly upstream of the bus arbiter (bs_gnrtr_n_rbtr).

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_term_fifo.sv | 96 +++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared bus-environment definitions: default sizes, packet type and destination-field layout.
// The checker and scoreboard use the same definitions.
package bus_pkg;

  localparam int PCKG_SZ_DEF    = 16;
  localparam int DRVS_DEF       = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef logic [PCKG_SZ_DEF-1:0] pkt_t;

  // Destination terminal ID occupies the top byte of a packet.
  localparam int          ID_MSB   = PCKG_SZ_DEF - 1;
  localparam int          ID_LSB   = PCKG_SZ_DEF - 8;
  localparam logic [7:0]  BCAST_ID = 8'hFF;

  function automatic logic [7:0] pkt_dest(input pkt_t p);
    return p[ID_MSB:ID_LSB];
  endfunction

  function automatic logic pkt_is_bcast(input pkt_t p);
    return pkt_dest(p) == BCAST_ID;
  endfunction

endpackage

// File: rtl/bus_term_fifo.sv
// Per-terminal show-ahead transmit FIFO feeding the bus arbiter.
// The head entry is presented on D_pop whenever pndng is high; the arbiter consumes it with pop.
module bus_term_fifo
  import bus_pkg::*;
#(
  parameter int width = PCKG_SZ_DEF,
  parameter int depth = FIFO_DEPTH_DEF,
  localparam int CNT_W = $clog2(depth + 1),
  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] D_in,
  output logic             full,
  output logic             pndng,
  input  logic             pop,
  output logic [width-1:0] D_pop,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  logic [width-1:0] r_mem [depth];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_pndng;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_ovf_evt;
  logic             w_udf_evt;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_count == CNT_W'(depth));
  assign w_pndng   = (r_count != '0);
  assign w_pop_ok  = pop & w_pndng;
  assign w_push_ok = push & (~w_full | w_pop_ok);
  assign w_ovf_evt = push & ~w_push_ok;
  assign w_udf_evt = pop & ~w_pndng;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= D_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error in the clearing cycle must survive the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~err_clr) | w_ovf_evt;
      r_underflow <= (r_underflow & ~err_clr) | w_udf_evt;
    end
  end

  assign full      = w_full;
  assign pndng     = w_pndng;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  // Gated so stale storage never shows through after reset.
  assign D_pop     = w_pndng ? r_mem[r_rd_ptr] : '0;

endmodule
